// File: rtl/ncl_ripple_adder_sync.sv
// Dual-rail NCL ripple-carry adder with a four-phase DATA/NULL completion handshake.
// Latency: one carry step per clock in EVAL (generate/kill bits may play ahead), +1 edge to DATA_HOLD.
// Backpressure: holds in NULL_WAIT / DATA_HOLD until out_comp requests the next wavefront.
module ncl_ripple_adder_sync #(
  parameter int WIDTH          = 8,
  parameter bit DATA_PLAYAHEAD = 1'b1,
  parameter bit NULL_PLAYAHEAD = 1'b0
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] a_f,
  input  logic [WIDTH-1:0] b_t,
  input  logic [WIDTH-1:0] b_f,
  input  logic             cin_t,
  input  logic             cin_f,
  input  logic             out_comp,
  output logic [WIDTH-1:0] sum_t,
  output logic [WIDTH-1:0] sum_f,
  output logic             cout_t,
  output logic             cout_f,
  output logic             in_comp,
  output logic             proto_err
);

  localparam int CW = $clog2(WIDTH + 2);
  // NULLING count value at which the last output has been cleared.
  localparam logic [CW-1:0] NULL_LAST = NULL_PLAYAHEAD ? CW'(1) : CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_NULL_WAIT = 2'd0,
    S_EVAL      = 2'd1,
    S_DATA_HOLD = 2'd2,
    S_NULLING   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operand rails captured on EVAL entry; also the reference for input-change detection.
  logic [WIDTH-1:0] r_a_t, r_a_f, r_b_t, r_b_f;
  logic             r_cin_t, r_cin_f;
  // Per carry position: known flag, carry value, and output-resolved flag (index WIDTH = cout).
  logic [WIDTH:0]   r_ck, r_cv, r_res;
  logic [CW-1:0]    r_ncnt;
  logic [WIDTH-1:0] r_sum_t, r_sum_f;
  logic             r_cout_t, r_cout_f, r_in_comp, r_err;

  logic             w_illegal, w_all_data, w_all_null, w_inputs_moved, w_eval_done;
  logic [WIDTH:0]   w_ck_init, w_cv_init;
  logic [WIDTH:1]   w_cnext;
  logic [WIDTH-1:0] w_sum_val;

  assign w_illegal      = (|(a_t & a_f)) | (|(b_t & b_f)) | (cin_t & cin_f);
  assign w_all_data     = (&(a_t ^ a_f)) & (&(b_t ^ b_f)) & (cin_t ^ cin_f);
  assign w_all_null     = ~(|{a_t, a_f, b_t, b_f, cin_t, cin_f});
  assign w_inputs_moved = ({a_t, a_f, b_t, b_f, cin_t, cin_f} !=
                           {r_a_t, r_a_f, r_b_t, r_b_f, r_cin_t, r_cin_f});
  assign w_eval_done    = &r_res;

  // Carry seeds at EVAL entry (a==b fixes the carry-out) and per-bit sum/carry from latched operands.
  always_comb begin
    w_ck_init    = '0;
    w_cv_init    = '0;
    w_cnext      = '0;
    w_sum_val    = '0;
    w_ck_init[0] = 1'b1;
    w_cv_init[0] = cin_t;
    for (int i = 0; i < WIDTH; i++) begin
      w_ck_init[i+1] = DATA_PLAYAHEAD && (a_t[i] == b_t[i]);
      w_cv_init[i+1] = a_t[i];
      w_sum_val[i]   = r_a_t[i] ^ r_b_t[i] ^ r_cv[i];
      w_cnext[i+1]   = (r_a_t[i] & r_b_t[i]) | (r_cv[i] & (r_a_t[i] ^ r_b_t[i]));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (init) r_state <= S_NULL_WAIT;
    else      r_state <= w_next;
  end

  // Next-state decode; an illegal input code freezes the handshake states.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_NULL_WAIT: if (!w_illegal && w_all_data && !out_comp) w_next = S_EVAL;
      S_EVAL:      if (w_eval_done) w_next = S_DATA_HOLD;
      S_DATA_HOLD: if (!w_illegal && w_all_null && out_comp) w_next = S_NULLING;
      S_NULLING:   if (r_ncnt == NULL_LAST) w_next = S_NULL_WAIT;
      default:     w_next = S_NULL_WAIT;
    endcase
  end

  // Datapath: operand capture, wavefront resolution, NULL wavefront, completion output.
  always_ff @(posedge clk) begin
    if (init) begin
      r_a_t     <= '0;
      r_a_f     <= '0;
      r_b_t     <= '0;
      r_b_f     <= '0;
      r_cin_t   <= 1'b0;
      r_cin_f   <= 1'b0;
      r_ck      <= '0;
      r_cv      <= '0;
      r_res     <= '0;
      r_ncnt    <= '0;
      r_sum_t   <= '0;
      r_sum_f   <= '0;
      r_cout_t  <= 1'b0;
      r_cout_f  <= 1'b0;
      r_in_comp <= 1'b0;
    end else begin
      unique case (r_state)
        S_NULL_WAIT: begin
          if (w_next == S_EVAL) begin
            r_a_t   <= a_t;
            r_a_f   <= a_f;
            r_b_t   <= b_t;
            r_b_f   <= b_f;
            r_cin_t <= cin_t;
            r_cin_f <= cin_f;
            r_ck    <= w_ck_init;
            r_cv    <= w_cv_init;
            r_res   <= '0;
          end
        end
        S_EVAL: begin
          if (w_eval_done) begin
            r_in_comp <= 1'b1;
          end else begin
            // Every bit whose carry-in is known drives its rails and publishes its carry-out.
            for (int i = 0; i < WIDTH; i++) begin
              if (r_ck[i]) begin
                r_res[i]   <= 1'b1;
                r_sum_t[i] <= w_sum_val[i];
                r_sum_f[i] <= ~w_sum_val[i];
                r_ck[i+1]  <= 1'b1;
                r_cv[i+1]  <= w_cnext[i+1];
              end
            end
            if (r_ck[WIDTH]) begin
              r_res[WIDTH] <= 1'b1;
              r_cout_t     <= r_cv[WIDTH];
              r_cout_f     <= ~r_cv[WIDTH];
            end
          end
        end
        S_DATA_HOLD: begin
          if (w_next == S_NULLING) r_ncnt <= '0;
        end
        S_NULLING: begin
          if (r_ncnt == NULL_LAST) begin
            r_in_comp <= 1'b0;
          end else begin
            r_ncnt <= r_ncnt + CW'(1);
            for (int i = 0; i < WIDTH; i++) begin
              if (NULL_PLAYAHEAD || (r_ncnt == CW'(i))) begin
                r_sum_t[i] <= 1'b0;
                r_sum_f[i] <= 1'b0;
              end
            end
            if (NULL_PLAYAHEAD || (r_ncnt == CW'(WIDTH))) begin
              r_cout_t <= 1'b0;
              r_cout_f <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky protocol error: illegal codes anywhere, disturbed inputs or out_comp in EVAL, data in NULLING.
  always_ff @(posedge clk) begin
    if (init) begin
      r_err <= 1'b0;
    end else if (w_illegal ||
                 ((r_state == S_EVAL) && (w_inputs_moved || out_comp)) ||
                 ((r_state == S_NULLING) && !w_all_null)) begin
      r_err <= 1'b1;
    end
  end

  assign sum_t     = r_sum_t;
  assign sum_f     = r_sum_f;
  assign cout_t    = r_cout_t;
  assign cout_f    = r_cout_f;
  assign in_comp   = r_in_comp;
  assign proto_err = r_err;

endmodule

// File: tb/tb_ncl_ripple_adder_sync.sv
// Testbench for ncl_ripple_adder_sync: two instances (data play-ahead + NULL ripple, strict ripple + NULL play-ahead).
// Timing is observed on falling edges; "cycle k" = outputs visible after the k-th edge following entry.
// Inputs and out_comp are shared; every wait on the DUT is bounded.
module tb_ncl_ripple_adder_sync;

  logic       clk = 1'b0;
  logic       init, out_comp, cin_t, cin_f;
  logic [7:0] a_t, a_f, b_t, b_f;
  logic [7:0] sum_t1, sum_f1, sum_t2, sum_f2;
  logic       cout_t1, cout_f1, cout_t2, cout_f2;
  logic       in_comp1, in_comp2, perr1, perr2;
  logic [8:0] o1_t, o1_f, o2_t, o2_f;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0][4:0] res1, res2, clr1, clr2;
  int              ic1, ic2, icn1, icn2;
  bit              mono_bad;

  localparam logic [8:0][4:0] CYC_RIPPLE = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [8:0][4:0] CYC_ONE    = {9{5'd1}};
  localparam logic [8:0][4:0] CYC_0F01   = {5'd1, 5'd1, 5'd1, 5'd1, 5'd4, 5'd3, 5'd2, 5'd1, 5'd1};

  always #5 clk = ~clk;

  assign o1_t = {cout_t1, sum_t1};
  assign o1_f = {cout_f1, sum_f1};
  assign o2_t = {cout_t2, sum_t2};
  assign o2_f = {cout_f2, sum_f2};

  ncl_ripple_adder_sync #(.WIDTH(8), .DATA_PLAYAHEAD(1'b1), .NULL_PLAYAHEAD(1'b0)) u_dp1 (
    .clk(clk), .init(init), .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .cin_t(cin_t), .cin_f(cin_f), .out_comp(out_comp),
    .sum_t(sum_t1), .sum_f(sum_f1), .cout_t(cout_t1), .cout_f(cout_f1),
    .in_comp(in_comp1), .proto_err(perr1));

  ncl_ripple_adder_sync #(.WIDTH(8), .DATA_PLAYAHEAD(1'b0), .NULL_PLAYAHEAD(1'b1)) u_dp0 (
    .clk(clk), .init(init), .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .cin_t(cin_t), .cin_f(cin_f), .out_comp(out_comp),
    .sum_t(sum_t2), .sum_f(sum_f2), .cout_t(cout_t2), .cout_f(cout_f2),
    .in_comp(in_comp2), .proto_err(perr2));

  task automatic drive_data(input logic [7:0] a, input logic [7:0] b, input logic cin);
    a_t = a; a_f = ~a; b_t = b; b_f = ~b; cin_t = cin; cin_f = ~cin;
  endtask

  task automatic drive_null();
    a_t = '0; a_f = '0; b_t = '0; b_f = '0; cin_t = 1'b0; cin_f = 1'b0;
  endtask

  // Present DATA (from a falling edge) and record per-output resolve cycle and in_comp rise cycle.
  task automatic run_eval(input logic [7:0] a, input logic [7:0] b, input logic cin);
    drive_data(a, b, cin);
    out_comp = 1'b0;
    res1 = '0; res2 = '0; ic1 = 0; ic2 = 0; mono_bad = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 30 && (ic1 == 0 || ic2 == 0); k++) begin
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        if (o1_t[i] | o1_f[i]) begin
          if (res1[i] == 5'd0) res1[i] = 5'(k);
        end else if (res1[i] != 5'd0) mono_bad = 1'b1;
        if (o2_t[i] | o2_f[i]) begin
          if (res2[i] == 5'd0) res2[i] = 5'(k);
        end else if (res2[i] != 5'd0) mono_bad = 1'b1;
      end
      if (in_comp1 && ic1 == 0) ic1 = k;
      if (in_comp2 && ic2 == 0) ic2 = k;
    end
    n_checks++;
    if (ic1 == 0 || ic2 == 0) begin
      n_errors++;
      $display("FAIL eval_timeout: in_comp %b/%b, required 1/1", in_comp1, in_comp2);
    end
  endtask

  // Present NULL with out_comp=1 and record per-output clear cycle and in_comp fall cycle.
  task automatic run_null();
    drive_null();
    out_comp = 1'b1;
    clr1 = '0; clr2 = '0; icn1 = 0; icn2 = 0;
    @(negedge clk);
    for (int k = 1; k <= 30 && (icn1 == 0 || icn2 == 0); k++) begin
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        if (!(o1_t[i] | o1_f[i]) && clr1[i] == 5'd0) clr1[i] = 5'(k);
        if (!(o2_t[i] | o2_f[i]) && clr2[i] == 5'd0) clr2[i] = 5'(k);
      end
      if (!in_comp1 && icn1 == 0) icn1 = k;
      if (!in_comp2 && icn2 == 0) icn2 = k;
    end
    n_checks++;
    if (icn1 == 0 || icn2 == 0) begin
      n_errors++;
      $display("FAIL null_timeout: in_comp %b/%b, required 0/0", in_comp1, in_comp2);
    end
    out_comp = 1'b0;
  endtask

  function automatic logic [8:0][4:0] exp_depth(input logic [7:0] a, input logic [7:0] b);
    logic [8:0][4:0] d;
    d[0] = 5'd1;
    for (int i = 1; i < 9; i++) d[i] = (a[i-1] == b[i-1]) ? 5'd1 : d[i-1] + 5'd1;
    return d;
  endfunction

  task automatic test_reset();
    init = 1'b1; out_comp = 1'b0; drive_null();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o1_t, o1_f, in_comp1, perr1} !== 20'h0) begin
      n_errors++; $display("FAIL reset_dp1: got %h, required 0", {o1_t, o1_f, in_comp1, perr1});
    end
    n_checks++;
    if ({o2_t, o2_f, in_comp2, perr2} !== 20'h0) begin
      n_errors++; $display("FAIL reset_dp0: got %h, required 0", {o2_t, o2_f, in_comp2, perr2});
    end
    init = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o1_t, o1_f, in_comp1, o2_t, o2_f, in_comp2} !== 38'h0) begin
      n_errors++; $display("FAIL idle_after_reset: got %h, required 0", {o1_t, o1_f, in_comp1, o2_t, o2_f, in_comp2});
    end
  endtask

  task automatic test_all_kill();
    run_eval(8'h00, 8'h00, 1'b0);
    n_checks++;
    if ({o1_t, o1_f, o2_t, o2_f} !== {9'h000, 9'h1FF, 9'h000, 9'h1FF}) begin
      n_errors++; $display("FAIL kill_value: got %h, required %h", {o1_t, o1_f, o2_t, o2_f}, {9'h000, 9'h1FF, 9'h000, 9'h1FF});
    end
    n_checks++;
    if (res1 !== CYC_ONE || ic1 != 2) begin
      n_errors++; $display("FAIL kill_timing_dp1: cycles %h in_comp@%0d, required %h in_comp@2", res1, ic1, CYC_ONE);
    end
    n_checks++;
    if (res2 !== CYC_RIPPLE || ic2 != 10) begin
      n_errors++; $display("FAIL kill_timing_dp0: cycles %h in_comp@%0d, required %h in_comp@10", res2, ic2, CYC_RIPPLE);
    end
    n_checks++;
    if (mono_bad) begin
      n_errors++; $display("FAIL kill_monotonic: a raised rail dropped during EVAL, required none");
    end
    run_null();
  endtask

  task automatic test_carry_chain();
    run_eval(8'hFF, 8'h00, 1'b1);
    n_checks++;
    if ({o1_t, o1_f, o2_t, o2_f} !== {9'h100, 9'h0FF, 9'h100, 9'h0FF}) begin
      n_errors++; $display("FAIL chain_value: got %h, required %h", {o1_t, o1_f, o2_t, o2_f}, {9'h100, 9'h0FF, 9'h100, 9'h0FF});
    end
    n_checks++;
    if (res1 !== CYC_RIPPLE || ic1 != 10) begin
      n_errors++; $display("FAIL chain_timing_dp1: cycles %h in_comp@%0d, required %h in_comp@10", res1, ic1, CYC_RIPPLE);
    end
    n_checks++;
    if (res2 !== CYC_RIPPLE || ic2 != 10) begin
      n_errors++; $display("FAIL chain_timing_dp0: cycles %h in_comp@%0d, required %h in_comp@10", res2, ic2, CYC_RIPPLE);
    end
    run_null();
  endtask

  task automatic test_playahead();
    run_eval(8'h0F, 8'h01, 1'b0);
    n_checks++;
    if ({o1_t, o1_f, o2_t, o2_f} !== {9'h010, 9'h1EF, 9'h010, 9'h1EF}) begin
      n_errors++; $display("FAIL playahead_value: got %h, required %h", {o1_t, o1_f, o2_t, o2_f}, {9'h010, 9'h1EF, 9'h010, 9'h1EF});
    end
    n_checks++;
    if (res1 !== CYC_0F01 || ic1 != 5) begin
      n_errors++; $display("FAIL playahead_timing_dp1: cycles %h in_comp@%0d, required %h in_comp@5", res1, ic1, CYC_0F01);
    end
    n_checks++;
    if (res2 !== CYC_RIPPLE || ic2 != 10) begin
      n_errors++; $display("FAIL playahead_timing_dp0: cycles %h in_comp@%0d, required %h in_comp@10", res2, ic2, CYC_RIPPLE);
    end
    n_checks++;
    if (mono_bad) begin
      n_errors++; $display("FAIL playahead_monotonic: a raised rail dropped during EVAL, required none");
    end
    run_null();
  endtask

  task automatic test_backpressure();
    drive_data(8'h5A, 8'h33, 1'b0);
    out_comp = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({o1_t, o1_f, in_comp1, o2_t, o2_f, in_comp2, perr1, perr2} !== 40'h0) begin
      n_errors++; $display("FAIL bp_null_wait: got %h, required 0", {o1_t, o1_f, in_comp1, o2_t, o2_f, in_comp2, perr1, perr2});
    end
    run_eval(8'h5A, 8'h33, 1'b0);
    n_checks++;
    if ({o1_t, o2_t} !== {9'h08D, 9'h08D}) begin
      n_errors++; $display("FAIL bp_value: got %h, required %h", {o1_t, o2_t}, {9'h08D, 9'h08D});
    end
    drive_null();
    out_comp = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({in_comp1, in_comp2, o1_t, o1_f, o2_t, o2_f} !== {2'b11, 9'h08D, 9'h172, 9'h08D, 9'h172}) begin
      n_errors++; $display("FAIL bp_data_hold: got %h, required %h", {in_comp1, in_comp2, o1_t, o1_f, o2_t, o2_f},
                           {2'b11, 9'h08D, 9'h172, 9'h08D, 9'h172});
    end
    run_null();
  endtask

  task automatic test_null_ripple();
    run_eval(8'h3C, 8'hA5, 1'b1);
    n_checks++;
    if ({o1_t, o2_t} !== {9'h0E2, 9'h0E2}) begin
      n_errors++; $display("FAIL nullrip_value: got %h, required %h", {o1_t, o2_t}, {9'h0E2, 9'h0E2});
    end
    run_null();
    n_checks++;
    if (clr1 !== CYC_RIPPLE || icn1 != 10) begin
      n_errors++; $display("FAIL null_ripple_dp1: cycles %h in_comp fall@%0d, required %h fall@10", clr1, icn1, CYC_RIPPLE);
    end
    n_checks++;
    if (clr2 !== CYC_ONE || icn2 != 2) begin
      n_errors++; $display("FAIL null_playahead_dp0: cycles %h in_comp fall@%0d, required %h fall@2", clr2, icn2, CYC_ONE);
    end
  endtask

  task automatic test_random();
    logic [7:0]      a, b;
    logic            c;
    logic [8:0]      exp;
    logic [8:0][4:0] d;
    int              mx;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
      d = exp_depth(a, b);
      mx = 0;
      for (int i = 0; i < 9; i++) if (int'(d[i]) > mx) mx = int'(d[i]);
      run_eval(a, b, c);
      n_checks++;
      if ({o1_t, o1_f} !== {exp, ~exp}) begin
        n_errors++; $display("FAIL rand_dp1 %h+%h+%b: got %h/%h, required %h", a, b, c, o1_t, o1_f, exp);
      end
      n_checks++;
      if ({o2_t, o2_f} !== {exp, ~exp}) begin
        n_errors++; $display("FAIL rand_dp0 %h+%h+%b: got %h/%h, required %h", a, b, c, o2_t, o2_f, exp);
      end
      n_checks++;
      if (res1 !== d || ic1 != mx + 1) begin
        n_errors++; $display("FAIL rand_timing_dp1 %h+%h: cycles %h in_comp@%0d, required %h in_comp@%0d", a, b, res1, ic1, d, mx + 1);
      end
      run_null();
    end
    n_checks++;
    if ({perr1, perr2} !== 2'b00) begin
      n_errors++; $display("FAIL clean_traffic_err: proto_err %b%b, required 00", perr1, perr2);
    end
  endtask

  task automatic test_illegal();
    drive_data(8'h00, 8'h00, 1'b0);
    a_t[3] = 1'b1;
    out_comp = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({perr1, perr2, in_comp1, in_comp2, o1_t, o1_f, o2_t, o2_f} !== {4'b1100, 36'h0}) begin
      n_errors++; $display("FAIL illegal_code: err %b%b in_comp %b%b outs %h, required err 11 in_comp 00 outs 0",
                           perr1, perr2, in_comp1, in_comp2, {o1_t, o1_f, o2_t, o2_f});
    end
    drive_null();
    @(negedge clk);
  endtask

  task automatic test_init_mid_eval();
    drive_data(8'hFF, 8'h00, 1'b1);
    out_comp = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sum_f1[2:0], sum_f2[2:0], perr1, perr2} !== 8'b011_011_11) begin
      n_errors++; $display("FAIL mid_eval_state: got %b, required 01101111", {sum_f1[2:0], sum_f2[2:0], perr1, perr2});
    end
    init = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o1_t, o1_f, o2_t, o2_f, in_comp1, in_comp2, perr1, perr2} !== 40'h0) begin
      n_errors++; $display("FAIL init_mid_eval: got %h, required 0", {o1_t, o1_f, o2_t, o2_f, in_comp1, in_comp2, perr1, perr2});
    end
    init = 1'b0;
    drive_null();
    @(negedge clk);
  endtask

  task automatic test_protocol_violations();
    bit done;
    drive_data(8'hFF, 8'h00, 1'b1);
    out_comp = 1'b0;
    repeat (2) @(negedge clk);
    b_t[0] = 1'b1; b_f[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({perr1, perr2} !== 2'b11) begin
      n_errors++; $display("FAIL eval_input_change: proto_err %b%b, required 11", perr1, perr2);
    end
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      done = in_comp1 && in_comp2;
    end
    n_checks++;
    if (!done || {o1_t, o2_t} !== {9'h100, 9'h100}) begin
      n_errors++; $display("FAIL latched_operands: in_comp %b%b sums %h, required 11 %h", in_comp1, in_comp2, {o1_t, o2_t}, {9'h100, 9'h100});
    end
    run_null();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    run_eval(8'h12, 8'h34, 1'b0);
    n_checks++;
    if ({perr1, perr2, o1_t, o2_t} !== {2'b00, 9'h046, 9'h046}) begin
      n_errors++; $display("FAIL pre_null_check: got %h, required %h", {perr1, perr2, o1_t, o2_t}, {2'b00, 9'h046, 9'h046});
    end
    drive_null();
    out_comp = 1'b1;
    @(negedge clk);
    a_t[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({perr1, perr2} !== 2'b11) begin
      n_errors++; $display("FAIL nulling_data: proto_err %b%b, required 11", perr1, perr2);
    end
    drive_null();
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      done = !in_comp1 && !in_comp2;
    end
    n_checks++;
    if (!done) begin
      n_errors++; $display("FAIL nulling_finish: in_comp %b%b, required 00", in_comp1, in_comp2);
    end
    out_comp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_kill();
    test_carry_chain();
    test_playahead();
    test_backpressure();
    test_null_ripple();
    test_random();
    test_illegal();
    test_init_mid_eval();
    test_protocol_violations();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
